// File: rtl/btn_cmd_pkg.sv
// Shared constants and helpers for the button command queue: command codes,
// pending-bit indices (ordered by arbitration priority) and the priority pick.
package btn_cmd_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned NUM_SRC = 5;

  typedef logic [CMD_W-1:0]   cmd_t;
  typedef logic [NUM_SRC-1:0] src_vec_t;

  localparam cmd_t CMD_NONE   = 3'd0;
  localparam cmd_t CMD_LEFT   = 3'd1;
  localparam cmd_t CMD_RIGHT  = 3'd2;
  localparam cmd_t CMD_ROTATE = 3'd3;
  localparam cmd_t CMD_DOWN   = 3'd4;
  localparam cmd_t CMD_DROP   = 3'd5;

  // Lower index wins arbitration.
  localparam int unsigned IDX_DROP   = 0;
  localparam int unsigned IDX_ROTATE = 1;
  localparam int unsigned IDX_LEFT   = 2;
  localparam int unsigned IDX_RIGHT  = 3;
  localparam int unsigned IDX_DOWN   = 4;

  // One-hot grant of the highest-priority (lowest-index) request.
  function automatic src_vec_t grant_of(input src_vec_t req);
    src_vec_t g;
    g = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic cmd_t code_of(input src_vec_t onehot);
    cmd_t c;
    c = CMD_NONE;
    if (onehot[IDX_DOWN])   c = CMD_DOWN;
    if (onehot[IDX_RIGHT])  c = CMD_RIGHT;
    if (onehot[IDX_LEFT])   c = CMD_LEFT;
    if (onehot[IDX_ROTATE]) c = CMD_ROTATE;
    if (onehot[IDX_DROP])   c = CMD_DROP;
    return c;
  endfunction

endpackage

// File: rtl/btn_cmd_fifo.sv
// Synchronous command FIFO with registered head/valid/level/full outputs.
// Simultaneous push and pop is allowed when full.
module btn_cmd_fifo
  import btn_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  cmd_t             wr_data,
  input  logic             rd_en,
  output cmd_t             head,
  output logic             valid,
  output logic [CNT_W-1:0] level,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cmd_t             head_q, head_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_rd, do_wr;

  always_comb begin
    do_rd    = rd_en & valid_q;
    do_wr    = wr_en & (~full_q | do_rd) & ~flush;
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    // The new head is the entry being written only when it lands at the new read pointer.
    if (count_d == '0) begin
      head_d = CMD_NONE;
    end else if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = CMD_NONE;
      valid_d  = 1'b0;
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= CMD_NONE;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign level = count_q;
  assign full  = full_q;

endmodule

// File: rtl/btn_cmd_queue.sv
// Encodes debounced button pulses into command codes, buffers them and hands
// them to the game FSM over valid/ready; coalesced presses raise a sticky flag.
module btn_cmd_queue
  import btn_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rotate,
  input  logic             btn_down,
  input  logic             btn_drop,
  input  logic             flush,
  input  logic             clr_overflow,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);

  src_vec_t pending_q, pending_d;
  logic     overflow_q, overflow_d;
  src_vec_t btn_vec, grant, lost;
  logic     pop_c, can_push, fifo_full, fifo_valid;
  cmd_t     fifo_head, wr_data;

  always_comb begin
    btn_vec             = '0;
    btn_vec[IDX_DROP]   = btn_drop;
    btn_vec[IDX_ROTATE] = btn_rotate;
    btn_vec[IDX_LEFT]   = btn_left;
    btn_vec[IDX_RIGHT]  = btn_right;
    btn_vec[IDX_DOWN]   = btn_down;

    pop_c    = fifo_valid & cmd_ready;
    can_push = ~fifo_full | pop_c;
    grant    = can_push ? grant_of(pending_q) : '0;
    wr_data  = code_of(grant);

    // A press is lost when its source is still waiting and is not served now.
    lost      = btn_vec & pending_q & ~grant;
    pending_d = flush ? '0 : ((pending_q & ~grant) | btn_vec);

    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (!flush && (lost != '0)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  btn_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (grant != '0),
    .wr_data (wr_data),
    .rd_en   (cmd_ready),
    .head    (fifo_head),
    .valid   (fifo_valid),
    .level   (level),
    .full    (fifo_full)
  );

  assign cmd_valid = fifo_valid;
  assign cmd_code  = fifo_head;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_cmd_queue.sv
// Directed bench for btn_cmd_queue: latency, priority order, full/pending
// behaviour, overflow set/clear, flush and asynchronous reset.
module tb_btn_cmd_queue;

  localparam int unsigned L   = 0;
  localparam int unsigned R   = 1;
  localparam int unsigned ROT = 2;
  localparam int unsigned D   = 3;
  localparam int unsigned DR  = 4;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic       flush;
  logic       clr_overflow;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] level;
  logic       overflow;

  int checks;
  int errors;

  btn_cmd_queue #(
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_left     (btn[L]),
    .btn_right    (btn[R]),
    .btn_rotate   (btn[ROT]),
    .btn_down     (btn[D]),
    .btn_drop     (btn[DR]),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .level        (level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic v, input logic [2:0] c,
                     input logic [2:0] lv, input logic o);
    check({tag, ".valid"},    8'(cmd_valid), 8'(v));
    check({tag, ".code"},     8'(cmd_code),  8'(c));
    check({tag, ".level"},    8'(level),     8'(lv));
    check({tag, ".overflow"}, 8'(overflow),  8'(o));
  endtask

  // Advance to the next falling edge (one rising edge applied), then drop pulses.
  task automatic tick();
    @(negedge clk);
    btn          = '0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    btn          = '0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    cmd_ready    = 1'b0;

    #2 chk("reset", 1'b0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(); chk("idle", 1'b0, 3'd0, 3'd0, 1'b0);

    // Single rotate: valid for exactly one cycle, two cycles after the pulse.
    cmd_ready = 1'b1;
    btn[ROT] = 1'b1; tick(); chk("t1.lat1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t1.out", 1'b1, 3'd3, 3'd1, 1'b0);
    tick(); chk("t1.done", 1'b0, 3'd0, 3'd0, 1'b0);

    // Same-cycle left/rotate/drop come out in priority order.
    btn[L] = 1'b1; btn[ROT] = 1'b1; btn[DR] = 1'b1;
    tick(); chk("t2.lat1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t2.drop", 1'b1, 3'd5, 3'd1, 1'b0);
    tick(); chk("t2.rot", 1'b1, 3'd3, 3'd1, 1'b0);
    tick(); chk("t2.left", 1'b1, 3'd1, 3'd1, 1'b0);
    tick(); chk("t2.done", 1'b0, 3'd0, 3'd0, 1'b0);

    // Fill with ready low; drop waits in pending, then drains in arrival order.
    cmd_ready = 1'b0;
    btn[L]   = 1'b1; tick(); chk("t3.a", 1'b0, 3'd0, 3'd0, 1'b0);
    btn[R]   = 1'b1; tick(); chk("t3.b", 1'b1, 3'd1, 3'd1, 1'b0);
    btn[ROT] = 1'b1; tick(); chk("t3.c", 1'b1, 3'd1, 3'd2, 1'b0);
    btn[D]   = 1'b1; tick(); chk("t3.d", 1'b1, 3'd1, 3'd3, 1'b0);
    btn[DR]  = 1'b1; tick(); chk("t3.full", 1'b1, 3'd1, 3'd4, 1'b0);
    tick(); chk("t3.hold", 1'b1, 3'd1, 3'd4, 1'b0);
    cmd_ready = 1'b1;
    tick(); chk("t3.o2", 1'b1, 3'd2, 3'd4, 1'b0);
    tick(); chk("t3.o3", 1'b1, 3'd3, 3'd3, 1'b0);
    tick(); chk("t3.o4", 1'b1, 3'd4, 3'd2, 1'b0);
    tick(); chk("t3.o5", 1'b1, 3'd5, 3'd1, 1'b0);
    tick(); chk("t3.done", 1'b0, 3'd0, 3'd0, 1'b0);

    // Coalescing down press while full; set beats clear; flush keeps overflow.
    cmd_ready = 1'b0;
    btn[L]   = 1'b1; tick(); chk("t4.a", 1'b0, 3'd0, 3'd0, 1'b0);
    btn[R]   = 1'b1; tick(); chk("t4.b", 1'b1, 3'd1, 3'd1, 1'b0);
    btn[ROT] = 1'b1; tick(); chk("t4.c", 1'b1, 3'd1, 3'd2, 1'b0);
    btn[L]   = 1'b1; tick(); chk("t4.d", 1'b1, 3'd1, 3'd3, 1'b0);
    btn[D]   = 1'b1; tick(); chk("t4.full", 1'b1, 3'd1, 3'd4, 1'b0);
    btn[D]   = 1'b1; tick(); chk("t4.coal", 1'b1, 3'd1, 3'd4, 1'b1);
    btn[D] = 1'b1; clr_overflow = 1'b1; tick(); chk("t4.setwins", 1'b1, 3'd1, 3'd4, 1'b1);
    flush = 1'b1; tick(); chk("t4.flush", 1'b0, 3'd0, 3'd0, 1'b1);
    clr_overflow = 1'b1; tick(); chk("t4.clr", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t4.nodown", 1'b0, 3'd0, 3'd0, 1'b0);

    // Full with a pop: left pushed in the same cycle and appears at the tail.
    btn[R]   = 1'b1; tick(); chk("t5.a", 1'b0, 3'd0, 3'd0, 1'b0);
    btn[ROT] = 1'b1; tick(); chk("t5.b", 1'b1, 3'd2, 3'd1, 1'b0);
    btn[D]   = 1'b1; tick(); chk("t5.c", 1'b1, 3'd2, 3'd2, 1'b0);
    btn[DR]  = 1'b1; tick(); chk("t5.d", 1'b1, 3'd2, 3'd3, 1'b0);
    btn[L]   = 1'b1; tick(); chk("t5.full", 1'b1, 3'd2, 3'd4, 1'b0);
    cmd_ready = 1'b1;
    tick(); chk("t5.pushpop", 1'b1, 3'd3, 3'd4, 1'b0);
    tick(); chk("t5.o4", 1'b1, 3'd4, 3'd3, 1'b0);
    tick(); chk("t5.o5", 1'b1, 3'd5, 3'd2, 1'b0);
    tick(); chk("t5.tail", 1'b1, 3'd1, 3'd1, 1'b0);
    tick(); chk("t5.done", 1'b0, 3'd0, 3'd0, 1'b0);

    // Flush at level 3 with right pending and a drop pulse in the same cycle.
    cmd_ready = 1'b0;
    btn[L]   = 1'b1; tick(); chk("t6.a", 1'b0, 3'd0, 3'd0, 1'b0);
    btn[ROT] = 1'b1; tick(); chk("t6.b", 1'b1, 3'd1, 3'd1, 1'b0);
    btn[D]   = 1'b1; tick(); chk("t6.c", 1'b1, 3'd1, 3'd2, 1'b0);
    btn[R]   = 1'b1; tick(); chk("t6.l3", 1'b1, 3'd1, 3'd3, 1'b0);
    flush = 1'b1; btn[DR] = 1'b1; tick(); chk("t6.flush", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t6.quiet1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t6.quiet2", 1'b0, 3'd0, 3'd0, 1'b0);

    // Overflow from arbitration loss, then asynchronous reset mid-stream.
    btn[L] = 1'b1; btn[R] = 1'b1; tick(); chk("t7.a", 1'b0, 3'd0, 3'd0, 1'b0);
    btn[R] = 1'b1; tick(); chk("t7.coal", 1'b1, 3'd1, 3'd1, 1'b1);
    tick(); chk("t7.b", 1'b1, 3'd1, 3'd2, 1'b1);
    #2 reset = 1'b1;
    #1 chk("t7.async", 1'b0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(); chk("t7.post1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick(); chk("t7.post2", 1'b0, 3'd0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_cmd_queue.md
Name: btn_cmd_queue

Overview:
Consumer end of the button-controller interface. Accepts the single-cycle debounced pulses produced by the per-button controllers (left, right, rotate, down, drop) and encodes each pulse into a 3-bit command code. Commands are buffered in a small FIFO and delivered to the game-logic FSM over a valid/ready handshake, so no button press is lost while the game FSM is busy (e.g. during line clear).

Parameters:
DEPTH, 4, FIFO depth in commands; power of 2, minimum 2.
CNT_W, 3, width of the level output; must hold DEPTH (log2(DEPTH)+1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_left  input  1  single-cycle pulse from the left button controller
btn_right  input  1  single-cycle pulse from the right button controller
btn_rotate  input  1  single-cycle pulse from the rotate button controller
btn_down  input  1  single-cycle pulse from the down button controller
btn_drop  input  1  single-cycle pulse from the drop button controller
flush  input  1  discard all pending and queued commands (new game / game over)
clr_overflow  input  1  clears the overflow flag
cmd_ready  input  1  game FSM accepts the head command this cycle
cmd_valid  output  1  head command available
cmd_code  output  3  head command: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN, 5 DROP; 0 when cmd_valid=0
level  output  CNT_W  number of commands currently in the FIFO
overflow  output  1  sticky flag: a press was coalesced and lost

Behaviour:
- Reset (async, active-high): pending=0, FIFO empty, cmd_valid=0, cmd_code=0, level=0, overflow=0. Reset asserted mid-operation drops everything immediately.
- Pending register (5 bits, one per source): pending_next = (pending & ~grant) | btn_*. Each pulse is captured at the clock edge.
- Arbiter: looks only at the registered pending value. Fixed priority DROP > ROTATE > LEFT > RIGHT > DOWN. One grant per cycle, issued only when pending≠0 and (FIFO not full, or a pop occurs this cycle). The granted code is written to the FIFO and its pending bit is cleared at the same edge.
- Latency: pulse sampled at edge N -> pending visible in cycle N+1 -> FIFO write at edge N+1 -> cmd_valid=1 in cycle N+2 (FIFO initially empty). Total latency is 2 cycles.
- Handshake: a pop occurs when cmd_valid & cmd_ready. cmd_valid and cmd_code are registered FIFO head outputs and stay stable until popped. cmd_ready while empty is ignored.
- Simultaneous push and pop when full: allowed. level remains DEPTH.
- Full FIFO with no pop: the grant is withheld and pending bits hold. Pending acts as a one-deep per-source extension.
- Coalescing: if a pulse arrives for a source whose pending bit is set and is not granted that cycle, the press merges into the pending bit and overflow is set to 1.
- overflow: sticky. clr_overflow clears it. If a set and a clear occur in the same cycle, set wins.
- flush: at the edge, pending=0, FIFO empty, level=0. btn_* pulses in the flush cycle are discarded. overflow is unaffected. The cmd_ready pop in that cycle is irrelevant.
- level: counts FIFO entries only. Pending bits are not counted. Pointers wrap modulo DEPTH. Full is detected when level == DEPTH.

Decomposition:
- Package btn_cmd_pkg: code constants CMD_NONE=0, CMD_LEFT=1, CMD_RIGHT=2, CMD_ROTATE=3, CMD_DOWN=4, CMD_DROP=5; CMD_W=3; pending-bit index constants in priority order.
- Sub-module btn_cmd_fifo: synchronous FIFO (DEPTH x CMD_W). Ports: wr_en, wr_data, rd_en, flush. Outputs: registered head, valid, level, full. Same clk/reset.
- Top level contains the pending register, the priority arbiter, and the overflow logic.

Test Plan:
- Single rotate pulse at cycle 10, cmd_ready=1 -> cmd_valid=1 with cmd_code=3 in cycle 12 only; level returns to 0; overflow=0.
- btn_left, btn_rotate and btn_drop pulsed in the same cycle, cmd_ready=1 -> codes appear in order 5, 3, 1 on consecutive cycles.
- cmd_ready=0; pulse all five buttons one per cycle -> level=4 holding 1, 2, 3, 4; DROP stays pending. Raise cmd_ready -> order 1, 2, 3, 4, 5; overflow=0.
- FIFO full, DOWN pending, second btn_down pulse -> overflow=1. Then clr_overflow together with a new coalescing btn_down pulse -> overflow remains 1. Then clr_overflow alone -> overflow=0.
- FIFO full with cmd_ready=1 and pending LEFT -> one pop and one push in the same cycle; level stays 4; LEFT enters at the tail.
- flush while level=3 and RIGHT pending, with a btn_drop pulse in the same cycle -> next cycle level=0, cmd_valid=0, no DROP emitted. Then assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
